// File: rtl/pps_edge_qualifier_if.sv
// PPS qualifier bus: synchronised PPS level in, strobes and status out.
interface pps_edge_qualifier_if #(
    parameter int CNT_W = 32
);
    logic             pps_sync;
    logic             pps_pulse;
    logic [CNT_W-1:0] period_cnt;
    logic             period_valid;
    logic             period_ok;
    logic             locked;
    logic             missing;
    logic [15:0]      glitch_cnt;

    // Source of the PPS level / consumer of the status
    modport master (
        output pps_sync,
        input  pps_pulse, period_cnt, period_valid, period_ok, locked, missing, glitch_cnt
    );

    // The qualifier itself
    modport slave (
        input  pps_sync,
        output pps_pulse, period_cnt, period_valid, period_ok, locked, missing, glitch_cnt
    );
endinterface

// File: rtl/pps_edge_qualifier.sv
// PPS edge qualifier: glitch filter, accepted-edge strobe, period measurement,
// tolerance check, lock tracking and missing-pulse detection.
module pps_edge_qualifier #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TOL         = 1000,
    parameter int MIN_HIGH    = 4,
    parameter int LOCK_COUNT  = 3,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pps_edge_qualifier_if.slave  bus
);
    localparam int HI_W = $clog2(MIN_HIGH + 1);
    localparam int GD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [HI_W-1:0]  HI_ONE  = HI_W'(1);
    localparam logic [HI_W-1:0]  HI_LAST = HI_W'(MIN_HIGH - 1);
    localparam logic [GD_W-1:0]  GD_ONE  = GD_W'(1);
    localparam logic [GD_W-1:0]  GD_MAX  = GD_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] PC_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(CLK_FREQ_HZ + TOL);
    // One extra bit so pc+1 and pc+1-nominal never overflow
    localparam logic [CNT_W:0]   X_ONE   = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]   X_NOM   = (CNT_W+1)'(CLK_FREQ_HZ);
    localparam logic [CNT_W:0]   X_TOL   = (CNT_W+1)'(TOL);

    typedef enum logic [1:0] {S_WAITLO, S_LOW, S_QUAL} state_t;

    state_t           state_q, state_d;
    logic [HI_W-1:0]  hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] pc_q, pc_d;
    logic             ref_seen_q, ref_seen_d;
    logic [GD_W-1:0]  good_cnt_q, good_cnt_d;
    logic             pps_pulse_q, pps_pulse_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic             period_valid_q, period_valid_d;
    logic             period_ok_q, period_ok_d;
    logic             locked_q, locked_d;
    logic             missing_q, missing_d;
    logic [15:0]      glitch_cnt_q, glitch_cnt_d;

    logic             accept, glitch, timeout, in_tol;
    logic [CNT_W:0]   pc_inc, pc_dev;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_WAITLO;
        else        state_q <= state_d;
    end

    // FSM next state; S_WAITLO blocks acceptance of a pulse already high
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAITLO: if (!bus.pps_sync) state_d = S_LOW;
            S_LOW:    if (bus.pps_sync) state_d = (MIN_HIGH == 1) ? S_WAITLO : S_QUAL;
            S_QUAL: begin
                if (!bus.pps_sync)           state_d = S_LOW;
                else if (hi_cnt_q == HI_LAST) state_d = S_WAITLO;
            end
            default:  state_d = S_WAITLO;
        endcase
    end

    // FSM outputs: accept on the MIN_HIGH-th high sample, glitch on early drop
    always_comb begin
        accept   = 1'b0;
        glitch   = 1'b0;
        hi_cnt_d = hi_cnt_q;
        case (state_q)
            S_LOW: if (bus.pps_sync) begin
                hi_cnt_d = HI_ONE;
                accept   = (MIN_HIGH == 1);
            end
            S_QUAL: begin
                if (!bus.pps_sync) begin
                    glitch = 1'b1;
                end else begin
                    hi_cnt_d = hi_cnt_q + HI_ONE;
                    accept   = (hi_cnt_q == HI_LAST);
                end
            end
            default: ;
        endcase
    end

    assign pc_inc  = {1'b0, pc_q} + X_ONE;
    assign pc_dev  = pc_inc - X_NOM;
    assign in_tol  = ($signed(pc_dev) <= $signed(X_TOL)) && ($signed(pc_dev) >= -$signed(X_TOL));
    // An accept in the timeout cycle wins and is measured as out of tolerance
    assign timeout = ref_seen_q && (pc_q == TIMEOUT) && !accept;

    // Period measurement, lock tracking and missing-pulse detection
    always_comb begin
        pc_d           = (pc_q == '1) ? pc_q : pc_q + PC_ONE;
        ref_seen_d     = ref_seen_q;
        good_cnt_d     = good_cnt_q;
        pps_pulse_d    = accept;
        period_cnt_d   = period_cnt_q;
        period_valid_d = 1'b0;
        period_ok_d    = period_ok_q;
        missing_d      = missing_q;
        glitch_cnt_d   = (glitch && glitch_cnt_q != 16'hFFFF) ? glitch_cnt_q + 16'd1 : glitch_cnt_q;
        if (accept) begin
            pc_d       = '0;
            missing_d  = 1'b0;
            ref_seen_d = 1'b1;
            if (ref_seen_q) begin
                period_valid_d = 1'b1;
                period_cnt_d   = pc_inc[CNT_W-1:0];
                period_ok_d    = in_tol;
                if (!in_tol)                 good_cnt_d = '0;
                else if (good_cnt_q != GD_MAX) good_cnt_d = good_cnt_q + GD_ONE;
            end
        end else if (timeout) begin
            missing_d   = 1'b1;
            ref_seen_d  = 1'b0;
            good_cnt_d  = '0;
            period_ok_d = 1'b0;
        end
        locked_d = (good_cnt_d == GD_MAX);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_cnt_q       <= '0;
            pc_q           <= '0;
            ref_seen_q     <= 1'b0;
            good_cnt_q     <= '0;
            pps_pulse_q    <= 1'b0;
            period_cnt_q   <= '0;
            period_valid_q <= 1'b0;
            period_ok_q    <= 1'b0;
            locked_q       <= 1'b0;
            missing_q      <= 1'b0;
            glitch_cnt_q   <= '0;
        end else begin
            hi_cnt_q       <= hi_cnt_d;
            pc_q           <= pc_d;
            ref_seen_q     <= ref_seen_d;
            good_cnt_q     <= good_cnt_d;
            pps_pulse_q    <= pps_pulse_d;
            period_cnt_q   <= period_cnt_d;
            period_valid_q <= period_valid_d;
            period_ok_q    <= period_ok_d;
            locked_q       <= locked_d;
            missing_q      <= missing_d;
            glitch_cnt_q   <= glitch_cnt_d;
        end
    end

    assign bus.pps_pulse    = pps_pulse_q;
    assign bus.period_cnt   = period_cnt_q;
    assign bus.period_valid = period_valid_q;
    assign bus.period_ok    = period_ok_q;
    assign bus.locked       = locked_q;
    assign bus.missing      = missing_q;
    assign bus.glitch_cnt   = glitch_cnt_q;
endmodule

// File: tb/tb_pps_edge_qualifier.sv
// Bench for pps_edge_qualifier: per-cycle vector table for qualification,
// then hand-written pulse trains for period, lock, glitch, miss and reset.
module tb_pps_edge_qualifier;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pps_edge_qualifier_if #(.CNT_W(CNT_W)) bus();

    pps_edge_qualifier #(
        .CLK_FREQ_HZ(1000), .TOL(10), .MIN_HIGH(4), .LOCK_COUNT(3), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        bit          rst_n;
        bit          pps;
        bit          exp_pulse;
        logic [15:0] exp_glitch;
    } vec_t;

    vec_t vt[$];

    int n_chk = 0, n_fail = 0, cyc = 0;
    int npulse, npv, last_pulse_cyc, miss_cyc;
    logic [CNT_W-1:0] pv_cnt;
    bit pv_ok, pv_lock, miss_prev;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, let the edge pass, sample and log events
    task automatic tick(input bit r, input bit p);
        rst_n = r;
        bus.pps_sync = p;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.pps_pulse) begin npulse++; last_pulse_cyc = cyc; end
        if (bus.period_valid) begin
            npv++; pv_cnt = bus.period_cnt; pv_ok = bus.period_ok; pv_lock = bus.locked;
        end
        if (bus.missing && !miss_prev) miss_cyc = cyc;
        miss_prev = bus.missing;
    endtask

    task automatic drive(input bit p, input int n);
        for (int i = 0; i < n; i++) tick(1'b1, p);
    endtask

    // 10-clock pulse, rising edge spacing s to the next pulse
    task automatic period(input int s);
        drive(1'b1, 10);
        drive(1'b0, s - 10);
    endtask

    task automatic clr();
        npulse = 0; npv = 0; pv_cnt = '0; pv_ok = 1'b0; pv_lock = 1'b0;
    endtask

    task automatic chk_pv(input string nm, input int cnt, input bit ok, input bit lk);
        chk({nm, "_npulse"}, npulse, 1);
        chk({nm, "_npv"}, npv, 1);
        chk({nm, "_cnt"}, pv_cnt, cnt);
        chk({nm, "_ok"}, pv_ok, ok);
        chk({nm, "_locked"}, pv_lock, lk);
    endtask

    function automatic void add(input bit r, input bit p, input bit ep, input int eg, input int n);
        vec_t v;
        v.rst_n = r; v.pps = p; v.exp_pulse = ep; v.exp_glitch = 16'(eg);
        for (int i = 0; i < n; i++) vt.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p_cyc, c0;
        bus.pps_sync = 1'b1;
        clr();
        miss_prev = 1'b0;
        miss_cyc = -1;
        last_pulse_cyc = -1;

        // Held high through reset, then low 5, high 10, then a 3-high glitch
        add(0, 1, 0, 0, 2);
        add(1, 1, 0, 0, 20);
        add(1, 0, 0, 0, 5);
        add(1, 1, 0, 0, 3);
        add(1, 1, 1, 0, 1);
        add(1, 1, 0, 0, 6);
        add(1, 0, 0, 0, 3);
        add(1, 1, 0, 0, 3);
        add(1, 0, 0, 1, 3);
        foreach (vt[i]) begin
            tick(vt[i].rst_n, vt[i].pps);
            chk($sformatf("vec%0d_pulse", i), bus.pps_pulse, vt[i].exp_pulse);
            chk($sformatf("vec%0d_glitch", i), bus.glitch_cnt, vt[i].exp_glitch);
            chk($sformatf("vec%0d_status", i),
                {bus.period_valid, bus.period_ok, bus.locked, bus.missing}, 0);
            chk($sformatf("vec%0d_pcnt", i), bus.period_cnt, 0);
        end

        // Fresh start for the pulse trains
        tick(1'b0, 1'b0);
        drive(1'b0, 2);

        // Five pulses at 1000 clocks
        for (int k = 1; k <= 5; k++) begin
            clr();
            period(1000);
            if (k == 1) begin
                chk("train1_npulse", npulse, 1);
                chk("train1_npv", npv, 0);
            end else begin
                chk_pv($sformatf("train%0d", k), 1000, 1'b1, k >= 4);
            end
        end

        // Glitch mid-period while locked
        clr();
        drive(1'b1, 10);
        drive(1'b0, 490);
        chk_pv("p6", 1000, 1'b1, 1'b1);
        clr();
        drive(1'b1, 3);
        drive(1'b0, 497);
        chk("glitch_npulse", npulse, 0);
        chk("glitch_cnt", bus.glitch_cnt, 1);
        chk("glitch_locked", bus.locked, 1);
        clr(); period(1011); chk_pv("p7", 1000, 1'b1, 1'b1);

        // Tolerance boundaries: 1011 bad (coincides with timeout), 1010/990 ok
        clr(); period(1010); chk_pv("p8", 1011, 1'b0, 1'b0);
        chk("p8_missing", bus.missing, 0);
        clr(); period(990);  chk_pv("p9", 1010, 1'b1, 1'b0);
        clr(); period(1000); chk_pv("p10", 990, 1'b1, 1'b0);
        clr(); period(1000); chk_pv("p11", 1000, 1'b1, 1'b1);

        // Omitted pulse
        p_cyc = last_pulse_cyc;
        clr();
        drive(1'b0, 1000);
        chk("miss_flag", bus.missing, 1);
        chk("miss_delay", miss_cyc - p_cyc, 1011);
        chk("miss_locked", bus.locked, 0);
        chk("miss_ok", bus.period_ok, 0);
        chk("miss_npv", npv, 0);
        clr(); period(1000);
        chk("after_miss_npulse", npulse, 1);
        chk("after_miss_npv", npv, 0);
        chk("after_miss_missing", bus.missing, 0);
        clr(); period(1000); chk_pv("p13", 1000, 1'b1, 1'b0);

        // Relock, then reset mid-qualification
        clr(); period(1000); chk_pv("p14", 1000, 1'b1, 1'b0);
        clr(); period(1000); chk_pv("p15", 1000, 1'b1, 1'b1);
        drive(1'b1, 2);
        tick(1'b0, 1'b1);
        chk("rst_status", {bus.pps_pulse, bus.period_valid, bus.period_ok, bus.locked, bus.missing}, 0);
        chk("rst_pcnt", bus.period_cnt, 0);
        chk("rst_glitch", bus.glitch_cnt, 0);
        clr();
        drive(1'b1, 20);
        chk("rst_held_npulse", npulse, 0);
        clr();
        drive(1'b0, 3);
        c0 = cyc;
        drive(1'b1, 10);
        chk("requal_npulse", npulse, 1);
        chk("requal_npv", npv, 0);
        chk("requal_latency", last_pulse_cyc - c0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
